// File: rtl/arb_requester.sv
// Initiator-side client for a two-port req/gnt arbiter.
// Requests the bus, streams a burst of beats from a local source, then releases.
module arb_requester #(
    parameter int DATA_W  = 8,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              abort,
    output logic              req,
    input  logic              gnt,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_pop,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_valid
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        XFER,
        REL
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [LEN_W-1:0]   beat_cnt;
    logic [LEN_W-1:0]   beat_nxt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [WAIT_W-1:0]  wait_nxt;
    logic               completed;
    logic               completed_nxt;
    logic               done_nxt;
    logic               timeout_nxt;
    logic               abort_nxt;
    logic               beat;

    // Beats pass straight through while the grant is held in XFER
    assign beat      = (state == XFER) && gnt;
    assign bus_valid = beat;
    assign src_pop   = beat;
    assign bus_data  = beat ? src_data : '0;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt     = state;
        beat_nxt      = beat_cnt;
        wait_nxt      = wait_cnt;
        completed_nxt = completed;
        done_nxt      = 1'b0;
        timeout_nxt   = 1'b0;
        abort_nxt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_nxt     = REQ;
                        beat_nxt      = len;
                        wait_nxt      = '0;
                        completed_nxt = 1'b0;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            REQ: begin
                if (gnt) begin
                    state_nxt = XFER;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt   = REL;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            XFER: begin
                if (gnt) begin
                    beat_nxt = beat_cnt - 1'b1;
                    if (beat_cnt == LEN_W'(1)) begin
                        state_nxt     = REL;
                        completed_nxt = 1'b1;
                    end
                end else begin
                    state_nxt = REL;
                    abort_nxt = 1'b1;
                end
            end
            REL: begin
                // Holding req low until the arbiter drops gnt forces a gap
                if (!gnt) begin
                    state_nxt     = IDLE;
                    done_nxt      = completed;
                    completed_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            wait_cnt  <= '0;
            completed <= 1'b0;
            req       <= 1'b0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            abort     <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_nxt;
            wait_cnt  <= wait_nxt;
            completed <= completed_nxt;
            req       <= (state_nxt == REQ) || (state_nxt == XFER);
            done      <= done_nxt;
            timeout   <= timeout_nxt;
            abort     <= abort_nxt;
        end
    end

endmodule

// File: tb/tb_arb_requester.sv
// Self-checking bench for arb_requester: directed scenarios plus randomized
// bursts checked cycle-by-cycle against a timeline model of each burst.
module tb_arb_requester;

    localparam int DW = 8;
    localparam int LW = 4;
    localparam int TO = 16;
    localparam int N  = 40;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [LW-1:0] len;
    logic          busy;
    logic          done;
    logic          timeout;
    logic          abort;
    logic          req;
    logic          gnt;
    logic [DW-1:0] src_data;
    logic          src_pop;
    logic [DW-1:0] bus_data;
    logic          bus_valid;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clock = ~clock;

    arb_requester #(
        .DATA_W (DW),
        .LEN_W  (LW),
        .TIMEOUT(TO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .timeout  (timeout),
        .abort    (abort),
        .req      (req),
        .gnt      (gnt),
        .src_data (src_data),
        .src_pop  (src_pop),
        .bus_data (bus_data),
        .bus_valid(bus_valid)
    );

    // {req, busy, bus_valid, src_pop, done, timeout, abort}
    function automatic logic [6:0] obs();
        return {req, busy, bus_valid, src_pop, done, timeout, abort};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        len   = '0;
        gnt   = 1'b0;
        src_data = 8'h5A;
        for (int t = 0; t < 3; t++) begin
            @(posedge clock); #1;
            @(negedge clock);
            n_chk++;
            if (obs() !== 7'b0 || bus_data !== 8'h00)
                $display("FAIL reset t=%0d outputs=%b data=%h expected=0000000 data=00",
                         t, obs(), bus_data);
            else n_pass++;
        end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // One burst: gnt is high in cycles [g_on, g_off) relative to the start
    // cycle, and falls for good one cycle after req is seen low.
    task automatic run_burst(input int l, input int g_on, input int g_off,
                             input logic [7:0] base, input string nm);
        int   beats;
        int   avail;
        int   t_rel;
        int   t_idle;
        int   outc;
        bit   granted;
        bit   ev;
        bit   rel_seen;
        logic [7:0] cur;
        logic [6:0] exp;
        granted = (g_on <= TO);
        avail   = g_off - g_on - 1;
        if (!granted) begin
            beats = 0;
            outc  = 2;
            t_rel = TO + 1;
        end else if (avail >= l) begin
            beats = l;
            outc  = 0;
            t_rel = g_on + beats + 1;
        end else begin
            beats = avail;
            outc  = 1;
            t_rel = g_on + beats + 2;
        end
        t_idle   = t_rel + ((t_rel >= g_on && t_rel < g_off) ? 2 : 1);
        cur      = base;
        rel_seen = 1'b0;
        for (int t = 0; t < N; t++) begin
            @(posedge clock); #1;
            start    = (t == 0);
            len      = LW'(l);
            gnt      = (t >= g_on) && (t < g_off) && !rel_seen;
            src_data = cur;
            @(negedge clock);
            ev  = granted && (t >= g_on + 1) && (t < g_on + 1 + beats);
            exp = {t >= 1 && t < t_rel, t >= 1 && t < t_idle, ev, ev,
                   outc == 0 && t == t_idle,
                   outc == 2 && t == t_rel,
                   outc == 1 && t == t_rel};
            n_chk++;
            if (obs() !== exp)
                $display("FAIL %s t=%0d outputs=%b expected=%b", nm, t, obs(), exp);
            else n_pass++;
            if (ev) begin
                n_chk++;
                if (bus_data !== cur)
                    $display("FAIL %s_data t=%0d bus_data=%h expected=%h", nm, t, bus_data, cur);
                else n_pass++;
                cur++;
            end
            if (t >= 1 && req === 1'b0) rel_seen = 1'b1;
        end
        start = 1'b0;
        gnt   = 1'b0;
    endtask

    task automatic test_basic();
        run_burst(3, 2, 99, 8'hA1, "basic_len3");
    endtask

    task automatic test_len_zero();
        logic [6:0] exp;
        for (int t = 0; t < 5; t++) begin
            @(posedge clock); #1;
            start = (t == 0);
            len   = '0;
            gnt   = 1'b0;
            @(negedge clock);
            exp = {4'b0000, t == 1, 2'b00};
            n_chk++;
            if (obs() !== exp)
                $display("FAIL len_zero t=%0d outputs=%b expected=%b", t, obs(), exp);
            else n_pass++;
        end
        start = 1'b0;
    endtask

    task automatic test_timeout();
        run_burst(2, 99, 99, 8'h10, "timeout");
    endtask

    task automatic test_abort();
        run_burst(5, 2, 5, 8'h30, "abort");
    endtask

    task automatic test_random();
        int l;
        int g_on;
        int g_off;
        for (int i = 0; i < 20; i++) begin
            l     = int'($urandom_range(1, 15));
            g_on  = int'($urandom_range(1, 20));
            g_off = g_on + 1 + int'($urandom_range(0, 17));
            run_burst(l, g_on, g_off, 8'($urandom), "random");
        end
    endtask

    // Paired arbiter: grants one cycle after it sees req, drops one cycle after
    task automatic test_back_to_back();
        logic req_prev;
        int   n_done;
        int   n_beat;
        int   n_rise;
        req_prev = 1'b0;
        n_done   = 0;
        n_beat   = 0;
        n_rise   = 0;
        for (int t = 0; t < 16; t++) begin
            @(posedge clock); #1;
            start = (t <= 6);
            len   = LW'(1);
            gnt   = req_prev;
            src_data = 8'(t);
            @(negedge clock);
            n_chk++;
            if (done !== (t == 6 || t == 12))
                $display("FAIL b2b_done t=%0d done=%b expected=%b", t, done, t == 6 || t == 12);
            else n_pass++;
            if (done === 1'b1) n_done++;
            if (bus_valid === 1'b1) n_beat++;
            if (req === 1'b1 && !req_prev) n_rise++;
            req_prev = req;
        end
        start = 1'b0;
        gnt   = 1'b0;
        n_chk++;
        if (n_done != 2 || n_beat != 2 || n_rise != 2)
            $display("FAIL b2b_counts done=%0d beats=%0d req_rises=%0d expected 2 2 2",
                     n_done, n_beat, n_rise);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 9; t++) begin
            @(posedge clock); #1;
            start = (t == 0);
            len   = LW'(4);
            reset = (t == 4);
            gnt   = (t >= 2) && (t <= 4);
            src_data = 8'hC0;
            @(negedge clock);
            if (t == 4) begin
                n_chk++;
                if (bus_valid !== 1'b1)
                    $display("FAIL reset_mid_beat2 bus_valid=%b expected=1", bus_valid);
                else n_pass++;
            end
            if (t >= 5) begin
                n_chk++;
                if (obs() !== 7'b0)
                    $display("FAIL reset_mid t=%0d outputs=%b expected=0000000", t, obs());
                else n_pass++;
            end
        end
        reset = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_timeout();
        test_abort();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
